mem_port_arbiter: RTL and testbench

Two-requester arbiter for the single shared memory port used by the multicycle CPU. Requester 0 is the CPU memory interface (instruction/data address, write enable, write data); requester 1 is the debug/program loader. The block grants one access at a time using round-robin priority. It drives the memory with registered signals, waits a fixed memory latency and returns read data with a one-cycle valid pulse to the owner. The CPU controller stalls its state machine until m0_rvalid.

---
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the shared single memory port
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..8");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       last_owner;
    logic       lat_we;
    logic       grant;
    logic       pick1;
    logic       sel_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // RESP doubles as an arbitration slot so back-to-back accesses need no idle gap
    always_comb begin
        state_nxt = state;
        pick1     = m1_req && (!m0_req || !last_owner);
        grant     = rst && (m0_req || m1_req) && (state == S_IDLE || state == S_RESP);
        sel_we    = pick1 ? m1_we : m0_we;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 3'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = grant ? S_ISSUE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign m0_gnt    = grant && !pick1;
    assign m1_gnt    = grant && pick1;
    assign m0_rvalid = (state == S_RESP) && !owner;
    assign m1_rvalid = (state == S_RESP) && owner;
    assign busy      = (state != S_IDLE);

    // mem_* are loaded on grant and live for the ISSUE cycle only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            cnt        <= 3'd0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            if (grant) begin
                mem_en     <= 1'b1;
                mem_we     <= sel_we;
                mem_adr    <= pick1 ? m1_adr : m0_adr;
                mem_wdata  <= pick1 ? m1_wdata : m0_wdata;
                owner      <= pick1;
                last_owner <= pick1;
                lat_we     <= sel_we;
            end
            if (state == S_ISSUE)
                cnt <= 3'(MEM_LAT - 1);
            else if (state == S_WAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;
            if (state == S_WAIT && cnt == 3'd0 && !lat_we)
                rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
    logic [31:0] a_m0_adr, a_m0_wdata, a_m1_adr, a_m1_wdata;
    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [31:0] a_rdata, a_mem_adr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_en, a_mem_we, a_busy, a_owner;

    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_adr, b_m0_wdata, b_m1_adr, b_m1_wdata;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_rdata, b_mem_adr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_en, b_mem_we, b_busy, b_owner;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_adr(a_m0_adr), .m0_wdata(a_m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_adr(a_m1_adr), .m1_wdata(a_m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid),
        .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_adr(a_mem_adr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_adr(b_m0_adr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_adr(b_m1_adr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid),
        .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_adr(b_mem_adr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        a_m0_req = 0; a_m1_req = 0; b_m0_req = 0; b_m1_req = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        a_m0_req = 1; a_m1_req = 1; a_m0_we = 0; a_m1_we = 0;
        a_m0_adr = 0; a_m1_adr = 0; a_m0_wdata = 0; a_m1_wdata = 0;
        a_mem_rdata = 32'hBAD0_BAD0;
        b_m0_req = 0; b_m1_req = 0; b_m0_we = 0; b_m1_we = 0;
        b_m0_adr = 0; b_m1_adr = 0; b_m0_wdata = 0; b_m1_wdata = 0;
        b_mem_rdata = 32'hBAD0_BAD0;

        // reset state with requests pending
        tick(); tick();
        check("rst_m0_gnt", a_m0_gnt, 0);
        check("rst_m1_gnt", a_m1_gnt, 0);
        check("rst_mem_en", a_mem_en, 0);
        check("rst_busy", a_busy, 0);
        check("rst_owner", a_owner, 0);
        check("rst_rdata", a_rdata, 0);
        check("rst_rvalid", {a_m0_rvalid, a_m1_rvalid}, 0);
        a_m1_req = 0;
        rst = 1'b1;

        // test 1: single read on port 0
        a_m0_adr = 32'h0000_3000;
        #1;
        check("t1_c0_m0_gnt", a_m0_gnt, 1);
        check("t1_c0_m1_gnt", a_m1_gnt, 0);
        tick();
        a_m0_req = 0; a_m0_adr = 32'hFFFF_FFFF;
        check("t1_c1_mem_en", a_mem_en, 1);
        check("t1_c1_mem_adr", a_mem_adr, 32'h0000_3000);
        check("t1_c1_mem_we", a_mem_we, 0);
        check("t1_c1_busy", a_busy, 1);
        tick();
        a_mem_rdata = 32'h2010_0005;
        check("t1_c2_mem_en", a_mem_en, 0);
        check("t1_c2_rvalid", a_m0_rvalid, 0);
        tick();
        a_mem_rdata = 32'hBAD0_BAD0;
        check("t1_c3_m0_rvalid", a_m0_rvalid, 1);
        check("t1_c3_m1_rvalid", a_m1_rvalid, 0);
        check("t1_c3_rdata", a_rdata, 32'h2010_0005);
        check("t1_c3_busy", a_busy, 1);
        tick();
        check("t1_c4_busy", a_busy, 0);
        check("t1_c4_rvalid", a_m0_rvalid, 0);

        // test 2: write from port 1
        a_m1_req = 1; a_m1_we = 1; a_m1_adr = 32'h0000_0010; a_m1_wdata = 32'hDEAD_BEEF;
        #1;
        check("t2_c0_m1_gnt", a_m1_gnt, 1);
        tick();
        a_m1_req = 0; a_m1_adr = 32'h1234_5678; a_m1_wdata = 0;
        check("t2_c1_mem_en", a_mem_en, 1);
        check("t2_c1_mem_we", a_mem_we, 1);
        check("t2_c1_mem_adr", a_mem_adr, 32'h0000_0010);
        check("t2_c1_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        check("t2_c1_owner", a_owner, 1);
        tick();
        check("t2_c2_mem_we", a_mem_we, 0);
        check("t2_c2_mem_wdata", a_mem_wdata, 0);
        tick();
        check("t2_c3_m1_rvalid", a_m1_rvalid, 1);
        check("t2_c3_m0_rvalid", a_m0_rvalid, 0);
        check("t2_c3_rdata", a_rdata, 32'h2010_0005);
        tick();
        check("t2_c4_m1_rvalid", a_m1_rvalid, 0);
        a_m1_we = 0;

        // test 4: MEM_LAT=4 read with a port 1 request arriving in cycle 2
        b_m0_req = 1; b_m0_adr = 32'h0000_0040;
        #1;
        check("t4_c0_m0_gnt", b_m0_gnt, 1);
        tick();
        b_m0_req = 0;
        check("t4_c1_mem_en", b_mem_en, 1);
        check("t4_c1_mem_adr", b_mem_adr, 32'h0000_0040);
        for (int c = 2; c <= 5; c++) begin
            tick();
            b_m1_req = 1;
            b_mem_rdata = (c == 5) ? 32'h5555_AAAA : 32'hBAD0_BAD0;
            #1;
            check($sformatf("t4_c%0d_m1_gnt", c), b_m1_gnt, 0);
            check($sformatf("t4_c%0d_rvalid", c), b_m0_rvalid, 0);
            check($sformatf("t4_c%0d_mem_en", c), b_mem_en, 0);
        end
        tick();
        b_mem_rdata = 32'hBAD0_BAD0;
        #1;
        check("t4_c6_m0_rvalid", b_m0_rvalid, 1);
        check("t4_c6_rdata", b_rdata, 32'h5555_AAAA);
        check("t4_c6_m1_gnt", b_m1_gnt, 1);
        tick();
        b_m1_req = 0;
        check("t4_c7_mem_en", b_mem_en, 1);
        check("t4_c7_owner", b_owner, 1);
        check("t4_c7_m0_rvalid", b_m0_rvalid, 0);

        // test 3: both ports held, grant order 0,1,0,1
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            a_m0_req = (c <= 9); a_m1_req = (c <= 9);
            #1;
            check($sformatf("t3_c%0d_m0_gnt", c), a_m0_gnt, (c % 3 == 0 && c <= 9 && (c / 3) % 2 == 0));
            check($sformatf("t3_c%0d_m1_gnt", c), a_m1_gnt, (c % 3 == 0 && c <= 9 && (c / 3) % 2 == 1));
            check($sformatf("t3_c%0d_m0_rv", c), a_m0_rvalid, (c % 3 == 0 && c >= 3 && (c / 3 - 1) % 2 == 0));
            check($sformatf("t3_c%0d_m1_rv", c), a_m1_rvalid, (c % 3 == 0 && c >= 3 && (c / 3 - 1) % 2 == 1));
            if (c >= 1) check($sformatf("t3_c%0d_owner", c), a_owner, ((c - 1) / 3) % 2);
            tick();
        end

        // test 6: back-to-back port 0 reads
        a_m0_req = 0; a_m1_req = 0;
        tick();
        for (int c = 0; c <= 9; c++) begin
            a_m0_req = (c < 9);
            a_mem_rdata = 32'h100 + c;
            #1;
            check($sformatf("t6_c%0d_gnt", c), a_m0_gnt, (c % 3 == 0 && c < 9));
            check($sformatf("t6_c%0d_rv", c), a_m0_rvalid, (c % 3 == 0 && c >= 3));
            if (c % 3 == 0 && c >= 3) check($sformatf("t6_c%0d_rdata", c), a_rdata, 32'h100 + c - 1);
            tick();
        end

        // test 5: reset during WAIT of a port 0 read
        a_m0_req = 1; a_m0_we = 0; a_m0_adr = 32'h0000_0080;
        #1;
        check("t5_c0_m0_gnt", a_m0_gnt, 1);
        tick();
        a_m0_req = 0;
        check("t5_c1_mem_en", a_mem_en, 1);
        tick();
        check("t5_c2_busy", a_busy, 1);
        rst = 1'b0;
        #1;
        check("t5_rst_mem_en", a_mem_en, 0);
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_rdata", a_rdata, 0);
        check("t5_rst_owner", a_owner, 0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t5_post%0d_rv", c), {a_m0_rvalid, a_m1_rvalid}, 0);
            tick();
        end
        a_m0_req = 1; a_m1_req = 1;
        #1;
        check("t5_first_m0_gnt", a_m0_gnt, 1);
        check("t5_first_m1_gnt", a_m1_gnt, 0);
        tick();
        a_m0_req = 0; a_m1_req = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
